// File: rtl/sail_mem_pkg.sv
// Shared definitions for the store buffer: access-code bit positions, FIFO entry
// layout, memory-port FSM states and load-path decisions.
package sail_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam int MASK_BYTE   = 0;
  localparam int MASK_HALF   = 1;
  localparam int MASK_WORD   = 2;
  localparam int MASK_SIGNED = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] sign_mask;
  } sb_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_RD_WAIT,
    PORT_WR_WAIT
  } port_state_t;

  typedef enum logic [1:0] {
    LOAD_ISSUE,
    LOAD_DRAIN,
    LOAD_FORWARD
  } load_path_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store FIFO: entry storage, head/tail/count bookkeeping and a per-slot
// word-address match vector against a probe address (only live slots can match).
module store_buffer_fifo
  import sail_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  sb_entry_t         push_entry,
  input  logic [ADDR_W-3:0] probe_word,
  output sb_entry_t         entries [DEPTH],
  output logic [PTR_W-1:0]  head,
  output logic [PTR_W:0]    count,
  output logic [DEPTH-1:0]  match
);

  sb_entry_t        store [DEPTH];
  logic [PTR_W-1:0] tail;

  // Storage holds no reset: slots only become visible through count.
  always_ff @(posedge clk) begin
    if (push) store[tail] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from head is below count.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = ({1'b0, PTR_W'(i) - head} < count) &&
                 (store[i].addr[ADDR_W-1:2] == probe_word);
    end
  end

  assign entries = store;

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer between the core load/store path and data memory.
// Define STORE_BUFFER_FWD_EN to serve word loads from a matching buffered word store.
module store_buffer
  import sail_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_memwrite,
  input  logic              core_memread,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [MASK_W-1:0] core_sign_mask,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_sign_mask,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sb_empty
);

  sb_entry_t        entries [DEPTH];
  sb_entry_t        head_entry;
  sb_entry_t        txn;
  logic [PTR_W-1:0] head;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] match;
  logic             push, pop, full, any_match;
  logic             load_done, load_armed, load_pending;
  logic             fwd_hit, fwd_fire;
  logic             launch_rd, launch_wr, rd_done;
  logic             txn_we;
  load_path_t       path;
  port_state_t      state, next_state;

  store_buffer_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry ('{addr: core_addr, wdata: core_wdata, sign_mask: core_sign_mask}),
    .probe_word (core_addr[ADDR_W-1:2]),
    .entries    (entries),
    .head       (head),
    .count      (count),
    .match      (match)
  );

  assign full         = (count == (PTR_W+1)'(DEPTH));
  assign sb_empty     = (count == '0);
  assign push         = core_memwrite & ~full;
  assign head_entry   = entries[head];
  assign any_match    = |match;
  assign load_pending = core_memread & ~load_done;
  assign core_stall   = (core_memwrite & full) | (core_memread & ~load_done);

`ifdef STORE_BUFFER_FWD_EN
  logic [PTR_W-1:0]  fwd_idx;
  logic [DATA_W-1:0] fwd_data;

  // Walk oldest to youngest so the last live match wins.
  always_comb begin
    fwd_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head + PTR_W'(k)]) fwd_idx = head + PTR_W'(k);
    end
  end

  assign fwd_hit  = any_match & core_sign_mask[MASK_WORD] & entries[fwd_idx].sign_mask[MASK_WORD];
  assign fwd_data = entries[fwd_idx].wdata;
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    path = LOAD_ISSUE;
    if (fwd_hit)        path = LOAD_FORWARD;
    else if (any_match) path = LOAD_DRAIN;
  end

  assign fwd_fire = load_pending & (path == LOAD_FORWARD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PORT_IDLE;
    else       state <= next_state;
  end

  // A load only launches once armed, i.e. one cycle after it was first seen.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    launch_rd  = 1'b0;
    launch_wr  = 1'b0;
    pop        = 1'b0;
    rd_done    = 1'b0;
    case (state)
      PORT_IDLE: begin
        if (load_armed && load_pending && path == LOAD_ISSUE) begin
          launch_rd  = 1'b1;
          mem_req    = 1'b1;
          next_state = PORT_RD_WAIT;
        end else if (count != '0) begin
          launch_wr  = 1'b1;
          mem_req    = 1'b1;
          next_state = PORT_WR_WAIT;
        end
      end
      PORT_RD_WAIT: begin
        if (mem_ready) begin
          rd_done    = 1'b1;
          next_state = PORT_IDLE;
        end
      end
      PORT_WR_WAIT: begin
        if (mem_ready) begin
          pop        = 1'b1;
          next_state = PORT_IDLE;
        end
      end
      default: next_state = PORT_IDLE;
    endcase
  end

  always_comb begin
    mem_we        = txn_we;
    mem_addr      = txn.addr;
    mem_wdata     = txn.wdata;
    mem_sign_mask = txn.sign_mask;
    if (launch_rd) begin
      mem_we        = 1'b0;
      mem_addr      = core_addr;
      mem_wdata     = '0;
      mem_sign_mask = core_sign_mask;
    end else if (launch_wr) begin
      mem_we        = 1'b1;
      mem_addr      = head_entry.addr;
      mem_wdata     = head_entry.wdata;
      mem_sign_mask = head_entry.sign_mask;
    end
  end

  // Transaction fields are held from launch until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn        <= '0;
      txn_we     <= 1'b0;
      load_done  <= 1'b0;
      load_armed <= 1'b0;
      core_rdata <= '0;
    end else begin
      if (launch_rd || launch_wr) begin
        txn_we <= mem_we;
        txn    <= '{addr: mem_addr, wdata: mem_wdata, sign_mask: mem_sign_mask};
      end
      load_done  <= rd_done | fwd_fire;
      load_armed <= load_pending & ~(rd_done | fwd_fire);
      if (rd_done) core_rdata <= mem_rdata;
`ifdef STORE_BUFFER_FWD_EN
      else if (fwd_fire) core_rdata <= fwd_data;
`endif
    end
  end

endmodule
